// File: rtl/avalon_pkg.sv
// Shared definitions for the seven-segment Avalon-MM initiator: FSM encoding,
// bus widths and counter sizing.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        LAT  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Bits needed to hold 0..max_value, never less than one bit.
    function automatic int cnt_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end else begin
            return $clog2(max_value + 1);
        end
    endfunction

endpackage

// File: rtl/avalon_stall_timer.sv
// Saturating waitrequest stall counter; expire flags the stalled cycle that
// brings the count up to TIMEOUT. TIMEOUT = 0 disables expiry.
module avalon_stall_timer
    import avalon_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] count_r;

    // Stall count register: clear wins over enable, holds at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry decode for the current stalled cycle.
    always_comb begin
        expire = 1'b0;
        if (TIMEOUT == 0) begin
            expire = 1'b0;
        end else if (enable && (count_r >= CNT_W'(TIMEOUT - 1))) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/seven_segment_avalon_master.sv
// Single-outstanding Avalon-MM initiator: takes one valid/ready command, runs
// it on the bus with waitrequest, fixed read latency and timeout, returns a response.
module seven_segment_avalon_master
    import avalon_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    input  logic [BE_W-1:0]   cmd_byteenable,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [BE_W-1:0]   avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int LAT_W = cnt_width(READ_LATENCY);

    state_t            state_r, state_next_s;
    logic              cmd_ready_r, cmd_ready_next_s;
    logic              rsp_valid_r, rsp_valid_next_s;
    logic [DATA_W-1:0] rsp_readdata_r, rsp_readdata_next_s;
    logic              rsp_error_r, rsp_error_next_s;
    logic [ADDR_W-1:0] avm_address_r, avm_address_next_s;
    logic              avm_read_r, avm_read_next_s;
    logic              avm_write_r, avm_write_next_s;
    logic [DATA_W-1:0] avm_writedata_r, avm_writedata_next_s;
    logic [BE_W-1:0]   avm_byteenable_r, avm_byteenable_next_s;
    logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_next_s;
    logic              stall_en_s, stall_clr_s, stall_expire_s;

    assign stall_en_s  = (state_r == BUS) && (avm_read_r || avm_write_r) && avm_waitrequest;
    assign stall_clr_s = (state_r != BUS);

    avalon_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (stall_en_s),
        .clear  (stall_clr_s),
        .expire (stall_expire_s)
    );

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_next_s          = state_r;
        avm_address_next_s    = avm_address_r;
        avm_read_next_s       = avm_read_r;
        avm_write_next_s      = avm_write_r;
        avm_writedata_next_s  = avm_writedata_r;
        avm_byteenable_next_s = avm_byteenable_r;
        rsp_readdata_next_s   = rsp_readdata_r;
        rsp_error_next_s      = rsp_error_r;
        lat_cnt_next_s        = lat_cnt_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    avm_address_next_s    = cmd_address;
                    avm_writedata_next_s  = cmd_writedata;
                    avm_byteenable_next_s = cmd_byteenable;
                    avm_write_next_s      = cmd_write;
                    avm_read_next_s       = !cmd_write;
                    state_next_s          = BUS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUS: begin
                if (!avm_waitrequest) begin
                    avm_read_next_s  = 1'b0;
                    avm_write_next_s = 1'b0;
                    rsp_error_next_s = 1'b0;
                    if (avm_write_r) begin
                        rsp_readdata_next_s = {DATA_W{1'b0}};
                        state_next_s        = RESP;
                    end else if (READ_LATENCY == 0) begin
                        rsp_readdata_next_s = avm_readdata;
                        state_next_s        = RESP;
                    end else begin
                        lat_cnt_next_s = LAT_W'(READ_LATENCY);
                        state_next_s   = LAT;
                    end
                end else if (stall_expire_s) begin
                    avm_read_next_s     = 1'b0;
                    avm_write_next_s    = 1'b0;
                    rsp_error_next_s    = 1'b1;
                    rsp_readdata_next_s = {DATA_W{1'b0}};
                    state_next_s        = RESP;
                end else begin
                    state_next_s = BUS;
                end
            end
            LAT: begin
                lat_cnt_next_s = lat_cnt_r - LAT_W'(1);
                if (lat_cnt_r <= LAT_W'(1)) begin
                    rsp_readdata_next_s = avm_readdata;
                    rsp_error_next_s    = 1'b0;
                    state_next_s        = RESP;
                end else begin
                    state_next_s = LAT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_error_next_s = 1'b0;
                    state_next_s     = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                avm_read_next_s  = 1'b0;
                avm_write_next_s = 1'b0;
                state_next_s     = IDLE;
            end
        endcase
    end

    assign cmd_ready_next_s = (state_next_s == IDLE);
    assign rsp_valid_next_s = (state_next_s == RESP);

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= IDLE;
            cmd_ready_r      <= 1'b0;
            rsp_valid_r      <= 1'b0;
            rsp_readdata_r   <= {DATA_W{1'b0}};
            rsp_error_r      <= 1'b0;
            avm_address_r    <= {ADDR_W{1'b0}};
            avm_read_r       <= 1'b0;
            avm_write_r      <= 1'b0;
            avm_writedata_r  <= {DATA_W{1'b0}};
            avm_byteenable_r <= {BE_W{1'b0}};
            lat_cnt_r        <= {LAT_W{1'b0}};
        end else begin
            state_r          <= state_next_s;
            cmd_ready_r      <= cmd_ready_next_s;
            rsp_valid_r      <= rsp_valid_next_s;
            rsp_readdata_r   <= rsp_readdata_next_s;
            rsp_error_r      <= rsp_error_next_s;
            avm_address_r    <= avm_address_next_s;
            avm_read_r       <= avm_read_next_s;
            avm_write_r      <= avm_write_next_s;
            avm_writedata_r  <= avm_writedata_next_s;
            avm_byteenable_r <= avm_byteenable_next_s;
            lat_cnt_r        <= lat_cnt_next_s;
        end
    end

    assign cmd_ready      = cmd_ready_r;
    assign rsp_valid      = rsp_valid_r;
    assign rsp_readdata   = rsp_readdata_r;
    assign rsp_error      = rsp_error_r;
    assign avm_address    = avm_address_r;
    assign avm_read       = avm_read_r;
    assign avm_write      = avm_write_r;
    assign avm_writedata  = avm_writedata_r;
    assign avm_byteenable = avm_byteenable_r;

endmodule

// File: tb/tb_seven_segment_avalon_master.sv
// Bench for seven_segment_avalon_master: instance a has READ_LATENCY 0, instance
// b has READ_LATENCY 2; both TIMEOUT 4 and share all inputs except readdata.
module tb_seven_segment_avalon_master;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_write, rsp_ready, avm_waitrequest;
    logic [3:0]  cmd_address, cmd_byteenable;
    logic [31:0] cmd_writedata, rd_value;
    logic        a_cmd_ready, a_rsp_valid, a_rsp_error, a_avm_read, a_avm_write;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_error, b_avm_read, b_avm_write;
    logic [31:0] a_rsp_readdata, a_avm_writedata, a_readdata;
    logic [31:0] b_rsp_readdata, b_avm_writedata, b_readdata;
    logic [3:0]  a_avm_address, a_avm_byteenable, b_avm_address, b_avm_byteenable;
    logic [1:0]  b_pipe;
    rsp_t        exp_a_q[$];
    rsp_t        exp_b_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    seven_segment_avalon_master #(.ADDR_W(4), .READ_LATENCY(0), .TIMEOUT(4)) u_a (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(a_rsp_readdata),
        .rsp_error(a_rsp_error), .avm_address(a_avm_address), .avm_read(a_avm_read),
        .avm_write(a_avm_write), .avm_writedata(a_avm_writedata), .avm_byteenable(a_avm_byteenable),
        .avm_readdata(a_readdata), .avm_waitrequest(avm_waitrequest)
    );

    seven_segment_avalon_master #(.ADDR_W(4), .READ_LATENCY(2), .TIMEOUT(4)) u_b (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_writedata(cmd_writedata), .cmd_byteenable(cmd_byteenable),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(b_rsp_readdata),
        .rsp_error(b_rsp_error), .avm_address(b_avm_address), .avm_read(b_avm_read),
        .avm_write(b_avm_write), .avm_writedata(b_avm_writedata), .avm_byteenable(b_avm_byteenable),
        .avm_readdata(b_readdata), .avm_waitrequest(avm_waitrequest)
    );

    // Slave models: a answers in the acceptance cycle, b exactly 2 cycles later.
    assign a_readdata = (a_avm_read && !avm_waitrequest) ? rd_value : 32'h0;
    assign b_readdata = b_pipe[1] ? 32'hDEADBEEF : 32'h0;

    always @(posedge clock) begin
        if (reset) b_pipe <= 2'b00;
        else       b_pipe <= {b_pipe[0], b_avm_read && !avm_waitrequest};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_cmd(input logic wr, input logic [3:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
        cmd_writedata = data; cmd_byteenable = be;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_cmd_ready === 1'b1 && b_cmd_ready === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_rsp_valid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 4'h0;
        cmd_writedata = 32'h0; cmd_byteenable = 4'h0; rsp_ready = 1'b1;
        avm_waitrequest = 1'b0; rd_value = 32'h0;
        repeat (3) tick();
        checks++;
        if ({a_cmd_ready, a_avm_read, a_avm_write, a_rsp_valid, a_rsp_error} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {a_cmd_ready, a_avm_read, a_avm_write, a_rsp_valid, a_rsp_error});
        end
        checks++;
        if (a_avm_address !== 4'h0 || a_avm_writedata !== 32'h0 || a_avm_byteenable !== 4'h0
            || a_rsp_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h wd %h be %h rd %h required all zero",
                     a_avm_address, a_avm_writedata, a_avm_byteenable, a_rsp_readdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (a_cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b%b required 11", a_cmd_ready, b_cmd_ready);
        end
    endtask

    task automatic test_write_no_stall();
        rsp_t exp;
        bit   ok;
        wait_idle(ok);
        avm_waitrequest = 1'b0; rsp_ready = 1'b1;
        exp_a_q.push_back('{data: 32'h0, err: 1'b0});
        drive_cmd(1'b1, 4'h0, 32'h000000A5, 4'hF);
        checks++;
        if ({a_avm_write, a_avm_read, a_cmd_ready} !== 3'b100 || a_avm_writedata !== 32'hA5
            || a_avm_byteenable !== 4'hF || a_avm_address !== 4'h0) begin
            errors++;
            $display("FAIL wr_strobe: wr/rd/rdy %b%b%b wd %h be %h required 100 a5 f",
                     a_avm_write, a_avm_read, a_cmd_ready, a_avm_writedata, a_avm_byteenable);
        end
        tick();
        exp = exp_a_q.pop_front();
        checks++;
        if ({a_avm_write, a_rsp_valid, a_rsp_readdata, a_rsp_error} !== {1'b0, 1'b1, exp.data, exp.err}) begin
            errors++;
            $display("FAIL wr_rsp: write %b valid %b data %h err %b required 0 1 %h %b",
                     a_avm_write, a_rsp_valid, a_rsp_readdata, a_rsp_error, exp.data, exp.err);
        end
        tick();
        checks++;
        if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_return: ready %b valid %b required 1 0", a_cmd_ready, a_rsp_valid);
        end
    endtask

    task automatic test_read_latency();
        rsp_t exp;
        bit   ok;
        int   na = -1;
        int   nb = -1;
        wait_idle(ok);
        rd_value = 32'h12345678;
        exp_a_q.push_back('{data: 32'h12345678, err: 1'b0});
        exp_b_q.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        drive_cmd(1'b0, 4'h3, 32'h0, 4'hF);
        checks++;
        if ({a_avm_read, a_avm_write} !== 2'b10 || a_avm_address !== 4'h3) begin
            errors++;
            $display("FAIL rd_strobe: rd/wr %b%b addr %h required 10 3", a_avm_read, a_avm_write, a_avm_address);
        end
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (a_rsp_valid === 1'b1 && na < 0) begin
                na = n;
                exp = exp_a_q.pop_front();
                checks++;
                if ({a_rsp_readdata, a_rsp_error} !== {exp.data, exp.err}) begin
                    errors++;
                    $display("FAIL rd_lat0_data: got %h/%b required %h/%b",
                             a_rsp_readdata, a_rsp_error, exp.data, exp.err);
                end
            end
            if (b_rsp_valid === 1'b1 && nb < 0) begin
                nb = n;
                exp = exp_b_q.pop_front();
                checks++;
                if ({b_rsp_readdata, b_rsp_error} !== {exp.data, exp.err}) begin
                    errors++;
                    $display("FAIL rd_lat2_data: got %h/%b required %h/%b",
                             b_rsp_readdata, b_rsp_error, exp.data, exp.err);
                end
            end
        end
        checks++;
        if (na != 1 || nb != 3) begin
            errors++;
            $display("FAIL rd_latency: response cycles %0d/%0d required 1/3", na, nb);
        end
    endtask

    task automatic test_timeout();
        rsp_t exp;
        bit   ok;
        int   cnt = 0;
        wait_idle(ok);
        avm_waitrequest = 1'b1; rd_value = 32'h5555AAAA;
        exp_a_q.push_back('{data: 32'h0, err: 1'b1});
        exp_b_q.push_back('{data: 32'h0, err: 1'b1});
        drive_cmd(1'b0, 4'h5, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            if (a_avm_read !== 1'b1) break;
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL tmo_strobe_len: read high %0d cycles required 4", cnt);
        end
        exp = exp_a_q.pop_front();
        checks++;
        if ({a_rsp_valid, a_rsp_readdata, a_rsp_error} !== {1'b1, exp.data, exp.err}) begin
            errors++;
            $display("FAIL tmo_rsp_a: valid %b data %h err %b required 1 %h %b",
                     a_rsp_valid, a_rsp_readdata, a_rsp_error, exp.data, exp.err);
        end
        exp = exp_b_q.pop_front();
        checks++;
        if ({b_rsp_valid, b_rsp_readdata, b_rsp_error} !== {1'b1, exp.data, exp.err}) begin
            errors++;
            $display("FAIL tmo_rsp_b: valid %b data %h err %b required 1 %h %b",
                     b_rsp_valid, b_rsp_readdata, b_rsp_error, exp.data, exp.err);
        end
        avm_waitrequest = 1'b0;
        tick();
        wait_idle(ok);
        exp_a_q.push_back('{data: 32'h0, err: 1'b0});
        drive_cmd(1'b1, 4'h1, 32'h000000FF, 4'h1);
        wait_a(ok);
        exp = exp_a_q.pop_front();
        checks++;
        if (!ok || {a_rsp_readdata, a_rsp_error} !== {exp.data, exp.err}) begin
            errors++;
            $display("FAIL tmo_recover: seen %b data %h err %b required 1 %h %b",
                     ok, a_rsp_readdata, a_rsp_error, exp.data, exp.err);
        end
        tick();
    endtask

    task automatic test_write_stall();
        rsp_t exp;
        bit   ok;
        bit   stable = 1'b1;
        bit   extra = 1'b0;
        int   cnt = 0;
        wait_idle(ok);
        avm_waitrequest = 1'b1;
        exp_a_q.push_back('{data: 32'h0, err: 1'b0});
        drive_cmd(1'b1, 4'hA, 32'h1234ABCD, 4'b0110);
        for (int i = 0; i < 10; i++) begin
            if (a_avm_write !== 1'b1) break;
            cnt++;
            if (a_avm_address !== 4'hA || a_avm_writedata !== 32'h1234ABCD || a_avm_byteenable !== 4'b0110)
                stable = 1'b0;
            avm_waitrequest = (cnt < 4) ? 1'b1 : 1'b0;
            tick();
        end
        checks++;
        if (cnt != 4 || !stable) begin
            errors++;
            $display("FAIL wr_stall_strobe: high %0d cycles stable %b required 4 1", cnt, stable);
        end
        exp = exp_a_q.pop_front();
        checks++;
        if ({a_rsp_valid, a_rsp_readdata, a_rsp_error} !== {1'b1, exp.data, exp.err}) begin
            errors++;
            $display("FAIL wr_stall_rsp: valid %b data %h err %b required 1 %h %b",
                     a_rsp_valid, a_rsp_readdata, a_rsp_error, exp.data, exp.err);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_rsp_valid !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL wr_stall_single_rsp: extra response seen required none");
        end
    endtask

    task automatic test_backpressure();
        rsp_t exp;
        bit   ok;
        bit   bad = 1'b0;
        wait_idle(ok);
        rsp_ready = 1'b0; rd_value = 32'hCAFEF00D;
        exp_a_q.push_back('{data: 32'hCAFEF00D, err: 1'b0});
        drive_cmd(1'b0, 4'h7, 32'h0, 4'hF);
        wait_a(ok);
        exp = exp_a_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 4'h9;
            if ({a_rsp_valid, a_rsp_readdata, a_rsp_error, a_cmd_ready} !== {1'b1, exp.data, exp.err, 1'b0})
                bad = 1'b1;
            tick();
        end
        checks++;
        if (!ok || bad) begin
            errors++;
            $display("FAIL bp_hold: seen %b unstable %b data %h ready %b required 1 0 %h 0",
                     ok, bad, a_rsp_readdata, a_cmd_ready, exp.data);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({a_rsp_valid, a_cmd_ready, a_avm_write, a_avm_read} !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release: valid/ready/wr/rd %b required 0100",
                     {a_rsp_valid, a_cmd_ready, a_avm_write, a_avm_read});
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        wait_idle(ok);
        avm_waitrequest = 1'b1;
        drive_cmd(1'b0, 4'h2, 32'h0, 4'hF);
        checks++;
        if (a_avm_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: read %b required 1", a_avm_read);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({a_avm_read, a_rsp_valid, b_avm_read, b_rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_drop: a rd/valid %b%b b rd/valid %b%b required 0000",
                     a_avm_read, a_rsp_valid, b_avm_read, b_rsp_valid);
        end
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || a_cmd_ready !== 1'b1 || a_avm_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: response %b ready %b read %b required 0 1 0",
                     seen, a_cmd_ready, a_avm_read);
        end
    endtask

    initial begin
        test_reset();
        test_write_no_stall();
        test_read_latency();
        test_timeout();
        test_write_stall();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d/%0d responses outstanding required 0/0",
                     exp_a_q.size(), exp_b_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_avalon_master.md
Name: seven_segment_avalon_master

Overview:
- Avalon-MM initiator (master) that drives memory-mapped slaves such as the seven-segment daisy-chain register from a simple valid/ready command port.
- Accepts one read or write command, runs it on the Avalon fabric with full waitrequest handling and fixed read latency, then returns a response.
- Sits between local control logic (display sequencer, test harness) and the Avalon slave port.
- One transaction is outstanding at a time.

Parameters:
- ADDR_W, 4: width of the Avalon word address.
- READ_LATENCY, 0: fixed slave read latency in cycles after read acceptance. 0 means readdata is valid in the acceptance cycle.
- TIMEOUT, 255: maximum number of waitrequest-stalled cycles before the request is aborted. 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target word address
- cmd_writedata  in  32  write data
- cmd_byteenable  in  4  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_readdata  out  32  read data; 0 for writes and for timeouts
- rsp_error  out  1  transaction aborted by timeout
- avm_address  out  ADDR_W  Avalon address
- avm_read  out  1  Avalon read strobe
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  32  Avalon write data
- avm_byteenable  out  4  Avalon byte enables
- avm_readdata  in  32  Avalon read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Clocking and reset: single clock `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - state = IDLE
  - cmd_ready = 0 during reset, 1 from the first cycle after reset releases
  - avm_read = avm_write = 0
  - avm_address, avm_writedata, avm_byteenable = 0
  - rsp_valid = rsp_error = 0, rsp_readdata = 0
  - stall and latency counters = 0
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch address, data, byteenable and write into the avm_* registers.
  - Assert avm_write, or avm_read, on the next cycle. Go to BUS.
- State BUS:
  - cmd_ready = 0.
  - avm_* outputs are held stable while avm_waitrequest = 1; the stall counter increments each such cycle.
  - Acceptance is a cycle with avm_waitrequest = 0 while the strobe is high.
    - Write acceptance: drop avm_write, load rsp_readdata = 0, go to RESP.
    - Read acceptance with READ_LATENCY = 0: capture avm_readdata this cycle into rsp_readdata, drop avm_read, go to RESP.
    - Read acceptance with READ_LATENCY > 0: drop avm_read, load the latency counter with READ_LATENCY, go to LAT.
  - Timeout: if TIMEOUT != 0 and the stall counter reaches TIMEOUT, drop the strobe, set rsp_error = 1 and rsp_readdata = 0, go to RESP.
  - The stall counter clears on leaving BUS.
- State LAT:
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1, capture avm_readdata, go to RESP.
  - Readdata is therefore sampled exactly READ_LATENCY cycles after the acceptance cycle.
- State RESP:
  - rsp_valid = 1. rsp_readdata and rsp_error are held stable until rsp_ready.
  - On rsp_valid and rsp_ready: clear rsp_valid and rsp_error, go to IDLE.
- Throughput:
  - Best case is one transaction per 3 cycles (IDLE, BUS, RESP) when rsp_ready is held high and waitrequest is low.
  - A command arriving while RESP is stalled waits; cmd_ready stays 0.
- Ignored inputs:
  - cmd_valid outside IDLE is ignored.
  - avm_readdata outside the capture cycle is ignored.
  - waitrequest is ignored while no strobe is high.
- Stall counter width is clog2(TIMEOUT + 1), minimum 1 bit. It saturates, never wraps.
- Reset mid-transaction: the strobe drops at the next edge, any pending response is discarded, and the block returns to IDLE.
- Never assert avm_read and avm_write together.

Decomposition:
- Shared package `avalon_pkg`:
  - state encoding constants IDLE = 0, BUS = 1, LAT = 2, RESP = 3
  - data width 32, byteenable width 4
- One sub-module, `avalon_stall_timer`: the saturating stall counter with enable, clear and timeout flag, parameterised by TIMEOUT.
- The FSM and datapath stay in the top module.

Test Plan:
- Write, no stall: cmd write addr 0x0, data 0x000000A5, be 0xF, rsp_ready = 1.
  - avm_write is high for exactly 1 cycle with writedata 0xA5.
  - rsp_valid pulses with rsp_readdata = 0 and rsp_error = 0.
  - cmd_ready returns 1 three cycles after acceptance.
- Write with 3-cycle waitrequest:
  - avm_write is high for 4 cycles, with address, data and byteenable unchanged across all four.
  - One response.
- Read, READ_LATENCY = 0: slave drives 0x12345678 in the acceptance cycle.
  - rsp_readdata = 0x12345678, rsp_error = 0.
- Read, READ_LATENCY = 2: readdata is 0xDEADBEEF only 2 cycles after acceptance, 0 otherwise.
  - rsp_readdata = 0xDEADBEEF.
- Timeout, TIMEOUT = 4: waitrequest held at 1 permanently.
  - Strobe drops after 4 stalled cycles.
  - rsp_error = 1, rsp_readdata = 0.
  - The next command is accepted and completes normally.
- Backpressure and reset:
  - rsp_ready = 0 for 5 cycles: rsp_valid and data stay stable, cmd_ready stays 0.
  - Reset asserted during BUS: avm_read is 0 at the next edge, no response is emitted, and the block is back in IDLE.
